// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// cam_pkg
// Shared definitions for the camera capture path: capture FSM state encoding
// and the default frame geometry used by frame_capture_ctrl and RAW2GRAY.
// Revision: 1.0
// ============================================================================
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    WAIT_SOF = 2'd2,
    CAPTURE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 960;
  localparam int DEF_DATA_W = 12;

endpackage
`default_nettype wire

// File: rtl/pixel_counter.sv
`default_nettype none
// ============================================================================
// pixel_counter
// Column/row position tracking for the capture window. Counters run only
// while en (CAPTURE) is high and are held at zero otherwise, so every frame
// starts at (0,0). Also flags any geometry violation.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   en              high while the controller is in CAPTURE
//   pix             a sensor pixel is present this cycle (fval & lval)
//   lval_fall       line valid falling edge
//   fval_fall       frame valid falling edge
//   col, row        current position of the pixel presented this cycle
//   pix_ok          position lies inside WIDTH x HEIGHT
//   size_err_set    one-cycle request to set the sticky size error
// Revision: 1.0
// ============================================================================
module pixel_counter #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pix,
  input  logic             lval_fall,
  input  logic             fval_fall,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             pix_ok,
  output logic             size_err_set
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] W_C     = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] H_C     = CNT_W'(HEIGHT);

  logic             line_close;
  logic [CNT_W-1:0] col_inc;
  logic [CNT_W-1:0] row_inc;
  logic [CNT_W-1:0] row_final;

  always_comb begin
    col_inc      = (col == CNT_MAX) ? col : col + CNT_W'(1);
    row_inc      = (row == CNT_MAX) ? row : row + CNT_W'(1);
    // A frame end closes a still-open line exactly like an lval fall would.
    line_close   = en && (lval_fall || fval_fall) && (col != '0);
    row_final    = line_close ? row_inc : row;
    pix_ok       = (col < W_C) && (row < H_C);
    size_err_set = 1'b0;
    if (en && pix && !pix_ok)
      size_err_set = 1'b1;
    if (line_close && (col != W_C))
      size_err_set = 1'b1;
    if (en && fval_fall && (row_final != H_C))
      size_err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (!en || fval_fall) begin
      col <= '0;
      row <= '0;
    end else if (line_close) begin
      col <= '0;
      row <= row_inc;
    end else if (pix) begin
      col <= col_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
// frame_capture_ctrl
// Gates the raw sensor stream by a host start/stop handshake and produces
// the registered pixel stream (pixel, valid, col, row) for RAW2GRAY.
// Capture always begins on a clean frame start so Bayer parity is exact.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           host pulse, arms a capture (ignored together with stop)
//   continuous      sampled on start accept: 1 = run until stop
//   stop            host pulse, ends capture at the next frame boundary
//   in_fval/lval    sensor frame / line valid
//   in_data         sensor raw pixel
//   pixel           registered pixel (1-cycle latency)
//   pixel_valid     pixel strobe
//   col_num/row_num position of the strobed pixel
//   busy            controller not in IDLE
//   frame_done      one-cycle pulse per captured frame
//   frame_count     frames completed since the last accepted start
//   size_err        sticky geometry error since the last accepted start
// Revision: 1.0
// ============================================================================
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              in_fval,
  input  logic              in_lval,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid,
  output logic [CNT_W-1:0]  col_num,
  output logic [CNT_W-1:0]  row_num,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic              size_err
);

  state_t           state;
  state_t           state_nxt;
  logic             fval_d;
  logic             lval_d;
  logic             cont_mode;
  logic             stop_req;

  logic             pix;
  logic             fval_rise;
  logic             fval_fall;
  logic             lval_fall;
  logic             in_cap;
  logic             start_acc;
  logic             frame_end;

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             pix_ok;
  logic             size_err_set;

  assign pix       = in_fval & in_lval;
  assign fval_rise = in_fval & ~fval_d;
  assign fval_fall = fval_d & ~in_fval;
  assign lval_fall = lval_d & ~in_lval;
  assign in_cap    = (state == CAPTURE);
  assign start_acc = (state == IDLE) && start && !stop;
  assign frame_end = in_cap && fval_fall;
  assign busy      = (state != IDLE);

  pixel_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CNT_W  (CNT_W)
  ) u_pixel_counter (
    .clk          (clk),
    .rst          (rst),
    .en           (in_cap),
    .pix          (pix),
    .lval_fall    (lval_fall),
    .fval_fall    (fval_fall),
    .col          (col),
    .row          (row),
    .pix_ok       (pix_ok),
    .size_err_set (size_err_set)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_acc) state_nxt = ARM;
      // Stay here while a frame is already running so it is dropped whole.
      ARM:      if (stop)          state_nxt = IDLE;
                else if (!in_fval) state_nxt = WAIT_SOF;
      WAIT_SOF: if (stop)           state_nxt = IDLE;
                else if (fval_rise) state_nxt = CAPTURE;
      CAPTURE:  if (fval_fall)
                  state_nxt = (cont_mode && !stop_req && !stop) ? WAIT_SOF : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fval_d      <= 1'b0;
      lval_d      <= 1'b0;
      cont_mode   <= 1'b0;
      stop_req    <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      col_num     <= '0;
      row_num     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      size_err    <= 1'b0;
    end else begin
      fval_d      <= in_fval;
      lval_d      <= in_lval;
      pixel_valid <= in_cap && pix && pix_ok;
      frame_done  <= frame_end;

      if (in_cap && pix && pix_ok) begin
        pixel   <= in_data;
        col_num <= col;
        row_num <= row;
      end

      if (start_acc) begin
        cont_mode   <= continuous;
        stop_req    <= 1'b0;
        frame_count <= '0;
        size_err    <= 1'b0;
      end else begin
        if (in_cap && stop) stop_req    <= 1'b1;
        if (frame_end)      frame_count <= frame_count + FCNT_W'(1);
        if (size_err_set)   size_err    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frame_capture_ctrl
// Directed bench for frame_capture_ctrl with an 8 x 4 frame. Frame drivers
// push the strobes and frame_done pulses the rules demand into queues,
// stamped with the cycle they must appear in; one compare process checks the
// DUT against those queues every clock.
// Revision: 1.0
// ============================================================================
module tb_frame_capture_ctrl;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int FCNT_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              continuous;
  logic              stop;
  logic              in_fval;
  logic              in_lval;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] pixel;
  logic              pixel_valid;
  logic [CNT_W-1:0]  col_num;
  logic [CNT_W-1:0]  row_num;
  logic              busy;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_count;
  logic              size_err;

  frame_capture_ctrl #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .FCNT_W (FCNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .stop        (stop),
    .in_fval     (in_fval),
    .in_lval     (in_lval),
    .in_data     (in_data),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .col_num     (col_num),
    .row_num     (row_num),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .size_err    (size_err)
  );

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] d;
    int                col;
    int                row;
  } exp_t;

  exp_t pq[$];
  int   fdq[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   strobes = 0;
  int   first_col = 99;
  int   first_row = 99;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison against the expected-event queues.
  always @(negedge clk) begin
    if (rst) begin
      logic exp_pv;
      logic exp_fd;
      exp_pv = (pq.size() > 0) && (pq[0].cyc == cyc);
      chk("pixel_valid", {31'd0, pixel_valid}, {31'd0, exp_pv});
      if (exp_pv) begin
        if (pixel_valid) begin
          chk("pixel", {20'd0, pixel}, {20'd0, pq[0].d});
          chk("col_num", {16'd0, col_num}, pq[0].col);
          chk("row_num", {16'd0, row_num}, pq[0].row);
        end
        void'(pq.pop_front());
      end
      exp_fd = (fdq.size() > 0) && (fdq[0] == cyc);
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      if (exp_fd) void'(fdq.pop_front());
      if (pixel_valid) begin
        strobes++;
        if (strobes == 1) begin
          first_col = int'(col_num);
          first_row = int'(row_num);
        end
      end
    end
  end

  task automatic do_start(input logic cont);
    continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Drives one sensor frame. cap says whether the controller must capture
  // it; start/stop may be pulsed in the gap before a given line, and a reset
  // may be applied in the middle of a given line.
  task automatic drive_frame(input int nlines, input int long_line, input bit cap,
                             input int start_line, input int stop_line, input int rst_line);
    int n;
    logic [DATA_W-1:0] d;
    tick();
    in_fval = 1'b1;
    tick();
    for (int l = 0; l < nlines; l++) begin
      if (l == start_line) begin
        start = 1'b1; tick(); start = 1'b0;
      end else if (l == stop_line) begin
        stop = 1'b1; tick(); stop = 1'b0;
      end else begin
        tick();
      end
      n = (l == long_line) ? WIDTH + 1 : WIDTH;
      for (int p = 0; p < n; p++) begin
        if (l == rst_line && p == 3) begin
          #6 rst = 1'b0;
          #1;
          chk("rst_pixel_valid", {31'd0, pixel_valid}, 0);
          chk("rst_pixel", {20'd0, pixel}, 0);
          chk("rst_col_num", {16'd0, col_num}, 0);
          chk("rst_row_num", {16'd0, row_num}, 0);
          chk("rst_busy", {31'd0, busy}, 0);
          chk("rst_frame_done", {31'd0, frame_done}, 0);
          chk("rst_frame_count", {16'd0, frame_count}, 0);
          chk("rst_size_err", {31'd0, size_err}, 0);
          in_fval = 1'b0;
          in_lval = 1'b0;
          tick();
          tick();
          rst = 1'b1;
          tick();
          return;
        end
        d = DATA_W'($urandom);
        in_lval = 1'b1;
        in_data = d;
        if (cap && p < WIDTH && l < HEIGHT)
          pq.push_back('{cyc + 1, d, p, l});
        tick();
      end
      in_lval = 1'b0;
      tick();
    end
    in_fval = 1'b0;
    if (cap) fdq.push_back(cyc + 1);
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    continuous = 1'b0;
    in_fval = 1'b0;
    in_lval = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pixel_valid", {31'd0, pixel_valid}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_frame_count", {16'd0, frame_count}, 0);
    chk("reset_size_err", {31'd0, size_err}, 0);
    chk("reset_col_row", {col_num, row_num}, 0);
    rst = 1'b1;
    tick();

    // Single-frame capture, then a frame that must be ignored.
    strobes = 0;
    first_col = 99;
    first_row = 99;
    do_start(1'b0);
    chk("single_busy_armed", {31'd0, busy}, 1);
    drive_frame(4, -1, 1'b1, -1, -1, -1);
    chk("single_strobes", strobes, 32);
    chk("single_first_pos", (first_row << 8) | first_col, 0);
    chk("single_frame_count", {16'd0, frame_count}, 1);
    chk("single_size_err", {31'd0, size_err}, 0);
    chk("single_idle", {31'd0, busy}, 0);
    strobes = 0;
    drive_frame(4, -1, 1'b0, -1, -1, -1);
    chk("single_ignored_strobes", strobes, 0);
    chk("single_ignored_count", {16'd0, frame_count}, 1);

    // Start while a frame is already in progress.
    continuous = 1'b0;
    strobes = 0;
    drive_frame(4, -1, 1'b0, 2, -1, -1);
    chk("midarm_dropped", strobes, 0);
    chk("midarm_busy", {31'd0, busy}, 1);
    first_col = 99;
    first_row = 99;
    drive_frame(4, -1, 1'b1, -1, -1, -1);
    chk("midarm_first_col", first_col, 0);
    chk("midarm_first_row", first_row, 0);
    chk("midarm_strobes", strobes, 32);
    chk("midarm_frame_count", {16'd0, frame_count}, 1);

    // Continuous capture, stop during the second frame.
    do_start(1'b1);
    drive_frame(4, -1, 1'b1, -1, -1, -1);
    chk("cont_busy_f1", {31'd0, busy}, 1);
    chk("cont_count_f1", {16'd0, frame_count}, 1);
    drive_frame(4, -1, 1'b1, -1, 1, -1);
    chk("cont_busy_after_stop", {31'd0, busy}, 0);
    chk("cont_count_f2", {16'd0, frame_count}, 2);
    strobes = 0;
    drive_frame(4, -1, 1'b0, -1, -1, -1);
    chk("cont_f3_strobes", strobes, 0);
    chk("cont_count_f3", {16'd0, frame_count}, 2);

    // Size error: 9-pixel first line, 3-line frame.
    do_start(1'b0);
    strobes = 0;
    drive_frame(3, 0, 1'b1, -1, -1, -1);
    chk("size_strobes", strobes, 24);
    chk("size_err_set", {31'd0, size_err}, 1);
    chk("size_frame_count", {16'd0, frame_count}, 1);
    repeat (5) tick();
    chk("size_err_held", {31'd0, size_err}, 1);

    // Start+stop together in IDLE is ignored.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    chk("startstop_idle", {31'd0, busy}, 0);
    chk("startstop_err_kept", {31'd0, size_err}, 1);

    // Accepted start clears size_err; stop in WAIT_SOF returns to IDLE.
    do_start(1'b0);
    chk("restart_err_clear", {31'd0, size_err}, 0);
    tick();
    tick();
    chk("waitsof_busy", {31'd0, busy}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("waitsof_stop_idle", {31'd0, busy}, 0);
    chk("waitsof_stop_count", {16'd0, frame_count}, 0);

    // Asynchronous reset during row 2, then a clean capture.
    do_start(1'b0);
    drive_frame(4, -1, 1'b1, -1, -1, 2);
    chk("postrst_idle", {31'd0, busy}, 0);
    do_start(1'b0);
    strobes = 0;
    first_col = 99;
    first_row = 99;
    drive_frame(4, -1, 1'b1, -1, -1, -1);
    chk("postrst_first_col", first_col, 0);
    chk("postrst_first_row", first_row, 0);
    chk("postrst_strobes", strobes, 32);
    chk("postrst_frame_count", {16'd0, frame_count}, 1);

    repeat (3) tick();
    chk("pix_queue_drained", pq.size(), 0);
    chk("fd_queue_drained", fdq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
